ntt_loop_ctrl: RTL and testbench

//  Parametrised loop controller for the NTT datapath: generates stage/group/butterfly

---
 rtl/ntt_loop_ctrl_if.sv | 29 ++
 rtl/ntt_loop_ctrl.sv | 161 ++++++++++++++++
 tb/tb_ntt_loop_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ntt_loop_ctrl_if.sv
// Handshake/index bundle between the top-level sequencer and the NTT loop controller.
// The sequencer side uses the master modport and the controller uses the slave modport.
interface ntt_loop_ctrl_if #(
    parameter int LOG_N = 8,
    parameter int PW    = 3
);
    logic             start;
    logic [1:0]       mode;
    logic             stall;
    logic [PW-1:0]    p;
    logic [LOG_N-1:0] k;
    logic [LOG_N-1:0] j;
    logic             ren;
    logic             sel;
    logic             en;
    logic             wen;
    logic             busy;
    logic             done;

    modport master (
        output start, mode, stall,
        input  p, k, j, ren, sel, en, wen, busy, done
    );

    modport slave (
        input  start, mode, stall,
        output p, k, j, ren, sel, en, wen, busy, done
    );
endinterface

// File: rtl/ntt_loop_ctrl.sv
// NTT loop controller: walks the (p, k, j) stage/group/butterfly loop nest for forward NTT,
// inverse NTT and point-wise multiply, and emits read/enable/write strobes as pure delays of
// the iteration-valid signal.
// Optional feature: define NTT_CTRL_STALL_EN to honour the stall input; otherwise it is ignored.
module ntt_loop_ctrl #(
    parameter int LOG_N      = 8,
    parameter int STAGE_BITS = 2,
    parameter int RD_LAT     = 1,
    parameter int EN_LAT     = 1,
    parameter int WR_LAT     = 14
) (
    input logic          clk,
    input logic          rst,
    ntt_loop_ctrl_if.slave bus
);
    localparam int P_MAX = LOG_N / STAGE_BITS;
    localparam int PW    = $clog2(P_MAX + 1);
    localparam int SW    = $clog2(LOG_N + 1);
    localparam int CW    = $clog2(WR_LAT + 1);

    localparam logic [1:0] ModeNtt  = 2'd0;
    localparam logic [1:0] ModePwm  = 2'd1;
    localparam logic [1:0] ModeIntt = 2'd2;
    localparam logic [1:0] ModeRsvd = 2'd3;

    localparam logic [LOG_N-1:0] IdxMax = '1;
    localparam logic [LOG_N:0]   One    = (LOG_N+1)'(1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_t;

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [PW-1:0]    p_q, p_d;
    logic [LOG_N-1:0] k_q, k_d, j_q, j_d;
    logic [CW-1:0]    drain_q, drain_d;

    logic [RD_LAT-1:0] rd_dl, sel_dl;
    logic [EN_LAT-1:0] en_dl;
    logic [WR_LAT-1:0] wr_dl;

    logic          stall_eff, iv, last, j_end, k_end;
    logic [SW-1:0] s;
    logic [LOG_N:0] j_lim, k_lim;

`ifdef NTT_CTRL_STALL_EN
    assign stall_eff = bus.stall;
`else
    assign stall_eff = 1'b0;
`endif

    assign iv = (state_q == StRun) && !stall_eff;

    // Loop bounds for the current stage; computed one bit wider so 2**LOG_N does not overflow.
    always_comb begin
        s     = SW'(p_q) * SW'(STAGE_BITS);
        j_lim = (One << s) - One;
        k_lim = ((One << LOG_N) >> s) - One;
        j_end = ({1'b0, j_q} == j_lim);
        k_end = ({1'b0, k_q} == k_lim);
        case (mode_q)
            ModePwm:  last = (k_q == IdxMax);
            ModeIntt: last = (p_q == PW'(P_MAX)) && (k_q == '0) && (j_q == IdxMax);
            default:  last = (p_q == '0) && (k_q == IdxMax) && (j_q == '0);
        endcase
    end

    // Next-state and loop-counter update.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        p_d     = p_q;
        k_d     = k_q;
        j_d     = j_q;
        drain_d = drain_q;
        case (state_q)
            StIdle: begin
                if (bus.start && bus.mode != ModeRsvd) begin
                    state_d = StRun;
                    mode_d  = bus.mode;
                    p_d     = (bus.mode == ModeNtt) ? PW'(P_MAX) : '0;
                    k_d     = '0;
                    j_d     = '0;
                end
            end
            StRun: begin
                if (iv) begin
                    if (last) begin
                        p_d     = '0;
                        k_d     = '0;
                        j_d     = '0;
                        drain_d = '0;
                        state_d = StDrain;
                    end else if (mode_q == ModePwm) begin
                        k_d = k_q + LOG_N'(1);
                    end else if (!j_end) begin
                        j_d = j_q + LOG_N'(1);
                    end else begin
                        j_d = '0;
                        if (!k_end) begin
                            k_d = k_q + LOG_N'(1);
                        end else begin
                            k_d = '0;
                            p_d = (mode_q == ModeNtt) ? p_q - PW'(1) : p_q + PW'(1);
                        end
                    end
                end
            end
            StDrain: begin
                // Hold until the final write strobe has left the delay line.
                if (drain_q == CW'(WR_LAT - 1)) state_d = StDone;
                else                            drain_d = drain_q + CW'(1);
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            mode_q  <= ModeNtt;
            p_q     <= '0;
            k_q     <= '0;
            j_q     <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            p_q     <= p_d;
            k_q     <= k_d;
            j_q     <= j_d;
            drain_q <= drain_d;
        end
    end

    // Strobe delay lines: shift iv in at bit 0, strobe taken from the top bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_dl  <= '0;
            sel_dl <= '0;
            en_dl  <= '0;
            wr_dl  <= '0;
        end else begin
            rd_dl  <= RD_LAT'({rd_dl, iv});
            sel_dl <= RD_LAT'({sel_dl, iv && (mode_q == ModeIntt)});
            en_dl  <= EN_LAT'({en_dl, iv});
            wr_dl  <= WR_LAT'({wr_dl, iv});
        end
    end

    assign bus.p    = p_q;
    assign bus.k    = k_q;
    assign bus.j    = j_q;
    assign bus.ren  = rd_dl[RD_LAT-1];
    assign bus.sel  = sel_dl[RD_LAT-1];
    assign bus.en   = en_dl[EN_LAT-1];
    assign bus.wen  = wr_dl[WR_LAT-1];
    assign bus.busy = (state_q != StIdle);
    assign bus.done = (state_q == StDone);
endmodule

// File: tb/tb_ntt_loop_ctrl.sv
// Scoreboard bench for ntt_loop_ctrl: stimulus pushes expected iterations and done records,
// a negedge monitor pops and compares them as ren/done appear.
module tb_ntt_loop_ctrl;
    localparam int LOG_N  = 8;
    localparam int PW     = 3;
    localparam int N      = 256;
    localparam int WR_LAT = 14;
`ifdef NTT_CTRL_STALL_EN
    localparam int STALL_DONE = 1300;
`else
    localparam int STALL_DONE = 1295;
`endif

    typedef struct {int p; int k; int j; int sel;} it_t;
    typedef struct {int rel; int iters;} dn_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ntt_loop_ctrl_if #(.LOG_N(LOG_N), .PW(PW)) bus ();

    ntt_loop_ctrl #(
        .LOG_N(LOG_N), .STAGE_BITS(2), .RD_LAT(1), .EN_LAT(1), .WR_LAT(WR_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    it_t exp_q[$];
    dn_t done_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc - t0);
        end
    endtask

    // Monitor: ren at cycle c+1 belongs to the indices seen at cycle c.
    int pp, pk, pj, n_ren, n_wen, n_en;
    it_t it;
    dn_t dn;
    always @(negedge clk) begin
        if (rst) begin
            n_ren = 0; n_wen = 0; n_en = 0;
        end else begin
            if (bus.ren) begin
                n_ren++;
                if (exp_q.size() == 0) chk("unexpected_ren", 1, 0);
                else begin
                    it = exp_q.pop_front();
                    chk("p", pp, it.p);
                    chk("k", pk, it.k);
                    chk("j", pj, it.j);
                    chk("sel", int'(bus.sel), it.sel);
                end
            end
            if (bus.wen) n_wen++;
            if (bus.en)  n_en++;
            if (bus.done) begin
                if (done_q.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    dn = done_q.pop_front();
                    chk("done_cycle", cyc - t0, dn.rel);
                    chk("ren_count", n_ren, dn.iters);
                    chk("wen_count", n_wen, dn.iters);
                    chk("en_count", n_en, dn.iters);
                    chk("busy_at_done", int'(bus.busy), 1);
                end
                n_ren = 0; n_wen = 0; n_en = 0;
            end
        end
        pp = int'(bus.p);
        pk = int'(bus.k);
        pj = int'(bus.j);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected loop nest written directly from the mode definitions.
    task automatic push_run(int m, int rel);
        int iters = 0;
        if (m == 1) begin
            for (int k = 0; k < N; k++) begin
                exp_q.push_back('{0, k, 0, 0});
                iters++;
            end
        end else begin
            for (int st = 0; st <= 4; st++) begin
                int p = (m == 0) ? 4 - st : st;
                int s = 2 * p;
                for (int k = 0; k < (N >> s); k++)
                    for (int j = 0; j < (1 << s); j++) begin
                        exp_q.push_back('{p, k, j, (m == 2) ? 1 : 0});
                        iters++;
                    end
            end
        end
        done_q.push_back('{rel, iters});
    endtask

    task automatic start_run(logic [1:0] m);
        bus.start = 1'b1;
        bus.mode  = m;
        t0 = cyc;
        tick();
        bus.start = 1'b0;
        bus.mode  = 2'd3;
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (bus.done) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("done_timeout", 0, 1);
    endtask

    task automatic chk_idle(string tag);
        chk({tag, "_p"}, int'(bus.p), 0);
        chk({tag, "_k"}, int'(bus.k), 0);
        chk({tag, "_j"}, int'(bus.j), 0);
        chk({tag, "_ren"}, int'(bus.ren), 0);
        chk({tag, "_sel"}, int'(bus.sel), 0);
        chk({tag, "_en"}, int'(bus.en), 0);
        chk({tag, "_wen"}, int'(bus.wen), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
    endtask

    initial begin
        int wcnt;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.mode  = 2'd0;
        bus.stall = 1'b0;
        tick();
        tick();
        chk_idle("reset");
        rst = 1'b0;
        tick();

        // Reserved mode is ignored in IDLE.
        start_run(2'd3);
        chk("mode3_busy0", int'(bus.busy), 0);
        tick();
        chk("mode3_busy1", int'(bus.busy), 0);

        // NTT with an ignored start mid-run and a start coincident with done.
        push_run(0, 1295);
        start_run(2'd0);
        while (cyc - t0 < 100) tick();
        bus.start = 1'b1;
        bus.mode  = 2'd1;
        tick();
        bus.start = 1'b0;
        chk("busy_ignored_start", int'(bus.busy), 1);
        wait_done();
        bus.start = 1'b1;
        bus.mode  = 2'd2;
        tick();
        bus.start = 1'b0;
        chk("busy_after_done", int'(bus.busy), 0);

        // PWM accepted the cycle after DONE.
        push_run(1, 271);
        start_run(2'd1);
        wait_done();
        tick();
        chk("pwm_busy_low", int'(bus.busy), 0);
        chk("pwm_done_low", int'(bus.done), 0);

        // INTT.
        push_run(2, 1295);
        start_run(2'd2);
        wait_done();
        tick();

        // NTT with stall cycles 10..14.
        push_run(0, STALL_DONE);
        start_run(2'd0);
        while (cyc - t0 < 10) tick();
        bus.stall = 1'b1;
        repeat (5) tick();
        bus.stall = 1'b0;
        wait_done();
        tick();

        // NTT aborted by reset at cycle 500.
        push_run(0, 1295);
        start_run(2'd0);
        while (cyc - t0 < 500) tick();
        exp_q.delete();
        done_q.delete();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle("midrst");
        wcnt = 0;
        repeat (20) begin
            tick();
            wcnt += int'(bus.wen) + int'(bus.ren) + int'(bus.busy);
        end
        chk("no_activity_after_rst", wcnt, 0);

        // Full NTT after the abort.
        push_run(0, 1295);
        start_run(2'd0);
        wait_done();
        tick();
        chk("final_busy", int'(bus.busy), 0);
        chk("exp_q_empty", exp_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
